// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor D = A - B, LSB first, one bit per clock.
// Optional macro SERSUB_OVERFLOW_EN adds a registered signed-overflow flag (ovf).
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   D,
`ifdef SERSUB_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   d_q, d_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
`ifdef SERSUB_OVERFLOW_EN
    logic             a_sign_q, a_sign_d;
    logic             b_sign_q, b_sign_d;
    logic             ovf_q, ovf_d;
`endif

    logic a_bit, b_bit, diff_bit, borrow_nx;
    logic accept, drain;

    // One full-subtractor cell working on the current LSBs.
    always_comb begin
        a_bit     = a_sh_q[0];
        b_bit     = b_sh_q[0];
        diff_bit  = a_bit ^ b_bit ^ borrow_q;
        borrow_nx = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q);
    end

    assign accept = in_valid && in_ready_q && (state_q == IDLE);
    assign drain  = out_valid_q && out_ready;

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        d_d      = d_q;
`ifdef SERSUB_OVERFLOW_EN
        a_sign_d = a_sign_q;
        b_sign_d = b_sign_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_sh_d   = A;
                    b_sh_d   = B;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
`ifdef SERSUB_OVERFLOW_EN
                    a_sign_d = A[WIDTH-1];
                    b_sign_d = B[WIDTH-1];
`endif
                    state_d  = RUN;
                end
            end
            RUN: begin
                res_d    = {diff_bit, res_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                borrow_d = borrow_nx;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    d_d     = {borrow_nx, diff_bit, res_q[WIDTH-1:1]};
`ifdef SERSUB_OVERFLOW_EN
                    // diff_bit here is the result sign bit.
                    ovf_d   = (a_sign_q != b_sign_q) && (diff_bit != a_sign_q);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (drain) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered off the current state, which gives
        // the one-cycle bubble after drain and the extra output cycle after RUN.
        in_ready_d  = (state_q == IDLE) && !accept;
        busy_d      = (state_q == RUN);
        out_valid_d = (state_q == DONE) && !drain;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_q       <= '0;
            borrow_q    <= 1'b0;
            cnt_q       <= '0;
            d_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SERSUB_OVERFLOW_EN
            a_sign_q    <= 1'b0;
            b_sign_q    <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_q       <= res_d;
            borrow_q    <= borrow_d;
            cnt_q       <= cnt_d;
            d_q         <= d_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef SERSUB_OVERFLOW_EN
            a_sign_q    <= a_sign_d;
            b_sign_q    <= b_sign_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign D         = d_q;
`ifdef SERSUB_OVERFLOW_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor (WIDTH=4) with an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W:0]   D;
    logic         busy;
`ifdef SERSUB_OVERFLOW_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
`ifdef SERSUB_OVERFLOW_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: unsigned difference with borrow, plus signed-overflow flag.
    function automatic logic [W:0] model_d(input int a, input int b);
        int low;
        low = (a - b + (1 << W)) % (1 << W);
        return {(a < b) ? 1'b1 : 1'b0, W'(low)};
    endfunction

    function automatic logic model_ovf(input int a, input int b);
        int sa, sb, sd;
        sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        sd = sa - sb;
        return (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
    endfunction

    // One full transaction: wait for in_ready, accept, optional noise on the
    // inputs while running, backpressure for hold cycles, drain, check bubble.
    task automatic do_op(input int a, input int b, input int hold, input bit noisy,
                         output logic [W:0] dres);
        int lat, nbusy, n;
        logic exp_ovf;
        n = 0;
        while (!in_ready && n < 40) begin
            tick;
            n++;
        end
        if (n >= 40) check_val("in_ready_wait_timeout", 32'(in_ready), 32'd1);
        A = W'(a);
        B = W'(b);
        in_valid = 1'b1;
        tick;
        in_valid = noisy;
        if (noisy) begin
            A = 1;
            B = 1;
        end
        check_val("in_ready_drop", 32'(in_ready), 32'd0);
        lat = 0;
        nbusy = 0;
        while (!out_valid && lat < 40) begin
            nbusy += int'(busy);
            if (noisy) begin
                A = W'($urandom);
                B = W'($urandom);
            end
            tick;
            lat++;
        end
        in_valid = 1'b0;
        check_val("latency", 32'(lat), 32'(W + 1));
        check_val("busy_cycles", 32'(nbusy), 32'(W));
        dres = D;
        check_val("D_model", 32'(D), 32'(model_d(a, b)));
`ifdef SERSUB_OVERFLOW_EN
        exp_ovf = model_ovf(a, b);
        check_val("ovf_model", 32'(ovf), 32'(exp_ovf));
`else
        exp_ovf = 1'b0;
`endif
        for (int i = 0; i < hold; i++) begin
            tick;
            check_val("bp_out_valid", 32'(out_valid), 32'd1);
            check_val("bp_D_stable", 32'(D), 32'(dres));
            check_val("bp_in_ready", 32'(in_ready), 32'd0);
`ifdef SERSUB_OVERFLOW_EN
            check_val("bp_ovf_stable", 32'(ovf), 32'(exp_ovf));
`endif
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check_val("drain_out_valid", 32'(out_valid), 32'd0);
        check_val("bubble_in_ready", 32'(in_ready), 32'd0);
        tick;
        check_val("in_ready_back", 32'(in_ready), 32'd1);
        check_val("no_second_result", 32'(out_valid), 32'd0);
        $display("op A=%0d B=%0d D=0x%0h hold=%0d noisy=%0d", a, b, dres, hold, noisy);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W:0] r;
        rst = 1'b1;
        tick;
        tick;
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_D", 32'(D), 32'd0);
        rst = 1'b0;
        tick;

        do_op(9, 3, 0, 1'b0, r);
        check_val("basic_D", 32'(r), 32'b0_0110);
        do_op(3, 9, 0, 1'b0, r);
        check_val("borrow_3_9", 32'(r), 32'b1_1010);
        do_op(0, 1, 0, 1'b0, r);
        check_val("borrow_0_1", 32'(r), 32'b1_1111);
        do_op(15, 15, 0, 1'b0, r);
        check_val("equal_15", 32'(r), 32'b0_0000);
        do_op(12, 5, 10, 1'b0, r);
        check_val("backpressure_D", 32'(r), 32'b0_0111);
        do_op(10, 4, 0, 1'b1, r);
        check_val("ignored_input_D", 32'(r), 32'b0_0110);

        // Abort in the second RUN cycle.
        A = 8;
        B = 2;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_val("abort_out_valid", 32'(out_valid), 32'd0);
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_in_ready", 32'(in_ready), 32'd1);
        check_val("abort_D", 32'(D), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick;
            check_val("abort_no_result", 32'(out_valid), 32'd0);
        end
        do_op(8, 2, 0, 1'b0, r);
        check_val("after_abort_D", 32'(r), 32'b0_0110);

        do_op(7, 15, 0, 1'b0, r);
        check_val("ovf_case_D", 32'(r), 32'b1_1000);
        do_op(5, 3, 0, 1'b0, r);
        check_val("noovf_case_D", 32'(r), 32'b0_0010);

        for (int i = 0; i < 40; i++) begin
            do_op(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                  int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), r);
        end

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_op(a, b, 0, 1'b0, r);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
